// File: rtl/line_draw_pkg.sv
// Shared types and constants for the line rasteriser and its memory controller.
package line_draw_pkg;

  localparam int unsigned H_RES   = 160;
  localparam int unsigned V_RES   = 120;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned ERR_W   = 11;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [ERR_W-1:0] err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_ACK,
    ST_STEP,
    ST_DONE
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  // Saturate a coordinate to the last valid pixel index of an axis of size lim.
  function automatic coord_t clamp_coord(input coord_t v, input int unsigned lim);
    if (32'(v) >= lim) begin
      return COORD_W'(lim - 32'd1);
    end
    return v;
  endfunction

  function automatic err_t to_err(input coord_t v);
    return $signed({{(ERR_W-COORD_W){1'b0}}, v});
  endfunction

  function automatic err_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? (to_err(a) - to_err(b)) : (to_err(b) - to_err(a));
  endfunction

endpackage

// File: rtl/line_draw_if.sv
// Command / pixel-write bus between a line requester, the rasteriser and the memory controller.
interface line_draw_if;
  import line_draw_pkg::*;

  logic   start;
  logic   abort;
  coord_t x0;
  coord_t y0;
  coord_t x1;
  coord_t y1;
  logic   wen_ack;
  coord_t xCoord_w;
  coord_t yCoord_w;
  logic   pix_valid;
  logic   busy;
  logic   done;

  modport master (
    output start, abort, x0, y0, x1, y1, wen_ack,
    input  xCoord_w, yCoord_w, pix_valid, busy, done
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, wen_ack,
    output xCoord_w, yCoord_w, pix_valid, busy, done
  );

endinterface

// File: rtl/line_draw.sv
// Bresenham line rasteriser: emits one framebuffer coordinate at a time and
// advances only after the memory controller acknowledges the write.
module line_draw #(
  parameter int unsigned H_RES = line_draw_pkg::H_RES,
  parameter int unsigned V_RES = line_draw_pkg::V_RES
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  line_draw_if.slave bus
);
  import line_draw_pkg::*;

  state_t     state_q, state_d;
  point_t     p0_q, p0_d;
  point_t     p1_q, p1_d;
  err_t       dx_q, dx_d;
  err_t       dy_q, dy_d;
  err_t       err_q, err_d;
  err_t       e2_c;
  logic       sx_neg_q, sx_neg_d;
  logic       sy_neg_q, sy_neg_d;
  logic [1:0] settle_q, settle_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       pix_valid_q, pix_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    settle_d    = settle_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = pix_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    e2_c        = err_q <<< 1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          p0_d    = '{x: clamp_coord(bus.x0, H_RES), y: clamp_coord(bus.y0, V_RES)};
          p1_d    = '{x: clamp_coord(bus.x1, H_RES), y: clamp_coord(bus.y1, V_RES)};
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        dx_d        = abs_diff(p1_q.x, p0_q.x);
        dy_d        = -abs_diff(p1_q.y, p0_q.y);
        err_d       = dx_d + dy_d;
        sx_neg_d    = (p0_q.x >= p1_q.x);
        sy_neg_d    = (p0_q.y >= p1_q.y);
        x_d         = p0_q.x;
        y_d         = p0_q.y;
        settle_d    = 2'd0;
        pix_valid_d = 1'b1;
        state_d     = ST_WAIT_ACK;
      end

      // The controller compares through a register stage, so the first two
      // acknowledge samples after a coordinate change are stale.
      ST_WAIT_ACK: begin
        if (settle_q != 2'd2) begin
          settle_d = settle_q + 2'd1;
        end else if (bus.wen_ack) begin
          if (x_q == p1_q.x && y_q == p1_q.y) begin
            pix_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end
      end

      ST_STEP: begin
        if (e2_c >= dy_q) begin
          err_d = err_d + dy_q;
          x_d   = sx_neg_q ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
        end
        if (e2_c <= dx_q) begin
          err_d = err_d + dx_q;
          y_d   = sy_neg_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
        end
        settle_d = 2'd0;
        state_d  = ST_WAIT_ACK;
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Cancel overrides everything, including an acknowledge in the same cycle.
    if (bus.abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      pix_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      settle_d    = 2'd0;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      p0_q        <= '0;
      p1_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      settle_q    <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      settle_q    <= settle_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.xCoord_w  = x_q;
  assign bus.yCoord_w  = y_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_line_draw.sv
// Self-checking bench for line_draw: random acknowledge timing, reference pixel lists from plain arithmetic.
module tb_line_draw;

  localparam int HR = 160;
  localparam int VR = 120;

  logic CLK_IN;
  logic RST_N;

  int checks = 0;
  int errors = 0;

  int exp_x[$];
  int exp_y[$];
  int obs_x[$];
  int obs_y[$];

  line_draw_if bus ();

  line_draw #(.H_RES(HR), .V_RES(VR)) dut (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .bus    (bus)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  function automatic int clampi(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference pixel sequence: clamp endpoints, then walk the error-term line.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
    int x, y, xe, ye, dx, dy, sx, sy, err, e2;
    exp_x.delete();
    exp_y.delete();
    x  = clampi(ax0, HR);
    y  = clampi(ay0, VR);
    xe = clampi(ax1, HR);
    ye = clampi(ay1, VR);
    dx = iabs(xe - x);
    dy = -iabs(ye - y);
    sx = (x < xe) ? 1 : -1;
    sy = (y < ye) ? 1 : -1;
    err = dx + dy;
    while (1) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (x == xe && y == ye) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic drive_idle();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.wen_ack = 1'b0;
    bus.x0 = 8'd0; bus.y0 = 8'd0; bus.x1 = 8'd0; bus.y1 = 8'd0;
  endtask

  // mode 0: random ack, mode 1: ack held high, mode 2: random ack plus spurious starts while busy.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int mode, input string name);
    int  px, py, hold, exp_n;
    bit  prev_v, got_done;
    model_line(ax0, ay0, ax1, ay1);
    exp_n = iabs(clampi(ax1, HR) - clampi(ax0, HR));
    if (iabs(clampi(ay1, VR) - clampi(ay0, VR)) > exp_n)
      exp_n = iabs(clampi(ay1, VR) - clampi(ay0, VR));
    exp_n = exp_n + 1;
    obs_x.delete();
    obs_y.delete();

    @(negedge CLK_IN);
    bus.x0 = 8'(ax0); bus.y0 = 8'(ay0); bus.x1 = 8'(ax1); bus.y1 = 8'(ay1);
    bus.wen_ack = 1'b0;
    bus.start   = 1'b1;
    @(negedge CLK_IN);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s latency1: busy=%0b pix_valid=%0b expected 1/0", name, bus.busy, bus.pix_valid);
    end
    @(negedge CLK_IN);
    checks++;
    if (bus.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency2: pix_valid=%0b expected 1", name, bus.pix_valid);
    end

    prev_v = 1'b0; got_done = 1'b0; hold = 0; px = -1; py = -1;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        bus.wen_ack = 1'b0;
        bus.start   = 1'b0;
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s done_cycle: pix_valid=%0b busy=%0b expected 0/1", name, bus.pix_valid, bus.busy);
        end
        if (mode == 1) begin
          checks++;
          if (hold < 3) begin
            errors++;
            $display("FAIL %s last_hold: held %0d cycles expected >=3", name, hold);
          end
        end
      end else begin
        if (bus.pix_valid === 1'b1) begin
          if (!prev_v || int'(bus.xCoord_w) != px || int'(bus.yCoord_w) != py) begin
            if (prev_v && mode == 1) begin
              checks++;
              if (hold < 3) begin
                errors++;
                $display("FAIL %s hold: pixel (%0d,%0d) held %0d cycles expected >=3", name, px, py, hold);
              end
            end
            px = int'(bus.xCoord_w);
            py = int'(bus.yCoord_w);
            obs_x.push_back(px);
            obs_y.push_back(py);
            hold = 1;
          end else begin
            hold++;
          end
        end
        prev_v = (bus.pix_valid === 1'b1);
        bus.wen_ack = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (mode == 2) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.x0 = 8'($urandom_range(0, 255)); bus.y0 = 8'($urandom_range(0, 255));
          bus.x1 = 8'($urandom_range(0, 255)); bus.y1 = 8'($urandom_range(0, 255));
        end
        @(negedge CLK_IN);
      end
    end

    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s timeout: done=0 expected done pulse", name);
    end else begin
      @(negedge CLK_IN);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: done=%0b busy=%0b expected 0/0", name, bus.done, bus.busy);
      end
    end

    checks++;
    if (obs_x.size() != exp_n) begin
      errors++;
      $display("FAIL %s count: got %0d pixels expected %0d", name, obs_x.size(), exp_n);
    end
    for (int i = 0; i < exp_x.size(); i++) begin
      checks++;
      if (i >= obs_x.size()) begin
        errors++;
        $display("FAIL %s pixel[%0d]: missing expected (%0d,%0d)", name, i, exp_x[i], exp_y[i]);
      end else if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got (%0d,%0d) expected (%0d,%0d)", name, i,
                 obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
      end
    end

    if (mode == 2) begin
      bit bad;
      bad = 1'b0;
      repeat (4) begin
        @(negedge CLK_IN);
        if (bus.busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s start_queued: busy rose after done expected 0", name);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    drive_idle();
    repeat (3) @(negedge CLK_IN);
    checks++;
    if (bus.xCoord_w !== 8'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", bus.xCoord_w); end
    checks++;
    if (bus.yCoord_w !== 8'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", bus.yCoord_w); end
    checks++;
    if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %0b expected 0", bus.pix_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK_IN);
  endtask

  task automatic test_horizontal();
    run_line(10, 5, 13, 5, 0, "horizontal");
  endtask

  task automatic test_diagonal();
    bit mono;
    run_line(0, 0, 3, 3, 0, "diagonal");
    run_line(5, 10, 4, 6, 0, "steep_reverse");
    mono = 1'b1;
    for (int i = 1; i < obs_y.size(); i++)
      if (obs_y[i] >= obs_y[i-1]) mono = 1'b0;
    checks++;
    if (!mono || obs_y.size() != 5) begin
      errors++;
      $display("FAIL steep_reverse_y: monotonic=%0b count=%0d expected 1/5", mono, obs_y.size());
    end
  endtask

  task automatic test_clamp();
    run_line(200, 130, 159, 119, 0, "clamp");
    checks++;
    if (obs_x.size() != 1 || obs_x[0] != 159 || obs_y[0] != 119) begin
      errors++;
      $display("FAIL clamp_pixel: got %0d pixels first (%0d,%0d) expected 1 at (159,119)",
               obs_x.size(), (obs_x.size() > 0) ? obs_x[0] : -1, (obs_y.size() > 0) ? obs_y[0] : -1);
    end
    run_line(7, 7, 7, 7, 0, "degenerate");
  endtask

  task automatic test_continuous_ack();
    run_line(2, 3, 9, 1, 1, "continuous_ack");
    run_line(30, 2, 25, 20, 1, "continuous_ack_steep");
  endtask

  task automatic test_start_while_busy();
    run_line(30, 40, 60, 45, 2, "start_while_busy");
  endtask

  task automatic test_reset_mid();
    int seen, px;
    bit prev_v, bad;
    logic [18:0] snap;
    @(negedge CLK_IN);
    bus.x0 = 8'd0; bus.y0 = 8'd0; bus.x1 = 8'd3; bus.y1 = 8'd0;
    bus.start = 1'b1;
    @(negedge CLK_IN);
    bus.start = 1'b0;
    bus.wen_ack = 1'b1;
    seen = 0; prev_v = 1'b0; px = -1;
    for (int cyc = 0; cyc < 100 && seen < 2; cyc++) begin
      @(negedge CLK_IN);
      if (bus.pix_valid === 1'b1 && (!prev_v || int'(bus.xCoord_w) != px)) begin
        seen++;
        px = int'(bus.xCoord_w);
      end
      prev_v = (bus.pix_valid === 1'b1);
    end
    checks++;
    if (seen != 2 || px != 1) begin
      errors++;
      $display("FAIL reset_mid_reach: reached pixel %0d at x=%0d expected 2 at x=1", seen, px);
    end
    #2 RST_N = 1'b0;
    #1;
    snap = {bus.xCoord_w, bus.yCoord_w, bus.pix_valid, bus.busy, bus.done};
    checks++;
    if (snap !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", snap);
    end
    bus.wen_ack = 1'b0;
    @(negedge CLK_IN);
    RST_N = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge CLK_IN);
      if (bus.done === 1'b1 || bus.busy === 1'b1 || bus.pix_valid === 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_after: activity after release expected idle");
    end
  endtask

  task automatic test_abort();
    bit bad;
    @(negedge CLK_IN);
    bus.x0 = 8'd20; bus.y0 = 8'd20; bus.x1 = 8'd40; bus.y1 = 8'd30;
    bus.wen_ack = 1'b0;
    bus.start = 1'b1;
    @(negedge CLK_IN);
    bus.start = 1'b0;
    repeat (4) @(negedge CLK_IN);
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: pix_valid=%0b busy=%0b expected 1/1", bus.pix_valid, bus.busy);
    end
    bus.abort = 1'b1;
    bus.wen_ack = 1'b1;
    @(negedge CLK_IN);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: pix_valid=%0b busy=%0b done=%0b expected 0/0/0",
               bus.pix_valid, bus.busy, bus.done);
    end
    bus.abort = 1'b0;
    bus.wen_ack = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK_IN);
      if (bus.done === 1'b1 || bus.busy === 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_after: done or busy seen after abort expected none");
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge CLK_IN);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: busy=%0b expected 0", bus.busy);
    end
    @(negedge CLK_IN);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle2: pix_valid=%0b busy=%0b expected 0/0", bus.pix_valid, bus.busy);
    end
  endtask

  task automatic test_random_lines();
    for (int n = 0; n < 12; n++) begin
      run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), $sformatf("random%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    run_line(100, 50, 90, 60, 0, "b2b_a");
    run_line(90, 60, 100, 50, 0, "b2b_b");
  endtask

  initial begin
    RST_N = 1'b0;
    drive_idle();
    test_reset();
    test_horizontal();
    test_diagonal();
    test_clamp();
    test_continuous_ack();
    test_start_while_busy();
    test_reset_mid();
    test_abort();
    test_random_lines();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
